irq_encoder8: RTL
=================

IRQ_ENCODER8 -- requirements
Module: irq_encoder8

Interface
REQ-001 SHALL have parameter: RESET_MASK, 8'hFF, mask register value after reset (1 = line enabled).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: irq  input  8  request lines, index 0 = highest priority.
REQ-005 SHALL have port: en  input  1  global enable for presenting requests.
REQ-006 SHALL have port: mask_we  input  1  write strobe for mask register.
REQ-007 SHALL have port: mask_wdata  input  8  new mask value.
REQ-008 SHALL have port: ack  input  1  consumer accepts current request.
REQ-009 SHALL have port: req_valid  output  1  a request is presented.
REQ-010 SHALL have port: req_id  output  3  encoded index of presented request.
REQ-011 SHALL have port: pending  output  8  latched pending bits (unmasked view).
REQ-012 SHALL have port: mask  output  8  current mask register.

Function
REQ-013 SHALL register irq into irq_q every cycle; rise = irq & ~irq_q.
REQ-014 SHALL set pending[i] on the edge after rise[i] is seen, regardless of mask or en.
REQ-015 SHALL implement two states: IDLE (req_valid=0), PRESENT (req_valid=1); all outputs registered.
REQ-016 IDLE -> PRESENT when en=1 and (pending & mask) != 0; req_id loaded with lowest set index of (pending & mask) in the same edge.
REQ-017 Latency: irq rising sampled at edge N -> pending set at edge N+1 -> req_valid=1 after edge N+2 (line masked-in, en=1, state IDLE).
REQ-018 In PRESENT, req_id SHALL stay stable until ack or en drop; a newly pending higher-priority line does not preempt.
REQ-019 PRESENT with ack=1 -> IDLE; pending[req_id] cleared on that edge; req_valid=0 for at least one cycle before the next request.
REQ-020 ack in IDLE SHALL be ignored (no pending bit changes).
REQ-021 Simultaneous clear by ack and new rise on the same line: set wins, pending bit remains 1.
REQ-022 PRESENT with en=0 -> IDLE without clearing pending (request withdrawn, re-presented when en returns).
REQ-023 mask_we=1 SHALL load mask_wdata into mask on that edge; mask change has no effect on a request already in PRESENT.
REQ-024 pending bits for masked lines SHALL be retained and become eligible once unmasked.
REQ-025 Level-held irq SHALL generate only one pending event; a new event requires irq to drop and rise again.

Reset
REQ-026 On rst=1 at a rising edge: state=IDLE, req_valid=0, req_id=0, pending=8'h00, irq_q=8'h00, mask=RESET_MASK.
REQ-027 rst SHALL override all other inputs, including ack, mask_we and rises in the same cycle; a line high across reset deassertion produces a rise on the first post-reset cycle.

Structure
REQ-028 Shared defines header SHALL hold N_IRQ=8, ID_W=3 and the state encodings IDLE=1'b0, PRESENT=1'b1.
REQ-029 The combinational lowest-index priority encoder SHALL be a separate sub-module prio_enc8 (in 8, out id 3, out any 1), reusable by other blocks.

Verification
REQ-030 Reset then irq=8'h10 for one cycle, en=1 -> req_valid=1, req_id=4 two edges after sampling; ack -> pending=8'h00, req_valid=0.
REQ-031 irq=8'h05 rising together -> req_id=0 first; ack; after one idle cycle, req_id=2; ack -> pending=0.
REQ-032 mask=8'hFE, irq[0] rises -> pending=8'h01, req_valid stays 0; write mask=8'hFF -> req_valid=1, req_id=0.
REQ-033 While PRESENT with req_id=3, irq[1] rises -> req_id remains 3 until ack; next grant req_id=1.
REQ-034 Ack of id 2 in same cycle as new rise on irq[2] -> pending[2]=1 after edge; req_id=2 presented again.
REQ-035 rst asserted while PRESENT with pending=8'h0C -> next cycle req_valid=0, pending=0, mask=8'hFF; en=0 during PRESENT -> req_valid=0, pending unchanged.

Source files
------------

// File: rtl/irq_encoder8_pkg.sv
// -----------------------------------------------------------------------------
// irq_encoder8_pkg
// Shared definitions for the 8-line interrupt encoder and its priority encoder.
//   N_IRQ   : number of request lines
//   ID_W    : width of an encoded request index
//   state_t : presentation state (IDLE = nothing offered, PRESENT = offered)
//   id_to_onehot : expands an encoded index into a one-hot line vector
// -----------------------------------------------------------------------------
package irq_encoder8_pkg;

   localparam int N_IRQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic logic [N_IRQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      return {{(N_IRQ-1){1'b0}}, 1'b1} << id;
   endfunction

endpackage

// File: rtl/irq_encoder8_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational lowest-index-wins priority encoder, free of any interrupt
// specific behaviour so other blocks can reuse it.
// Ports:
//   i_req [7:0] : request vector, bit 0 has the highest priority
//   o_id  [2:0] : index of the lowest set bit (0 when no bit is set)
//   o_any       : at least one bit of i_req is set
// -----------------------------------------------------------------------------
module prio_enc8
   import irq_encoder8_pkg::*;
(
   input  logic [N_IRQ-1:0] i_req,
   output logic [ID_W-1:0]  o_id,
   output logic             o_any
);

   always_comb begin
      // NOTE: every output of an always_comb gets a default before any
      // conditional assignment, otherwise a path that skips the assignment
      // infers a latch.
      o_id  = '0;
      o_any = |i_req;
      // Scan from the top down so the lowest set index is the last writer.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_encoder8.sv
// -----------------------------------------------------------------------------
// irq_encoder8
// Edge-detecting 8-line interrupt encoder. Rising edges on irq are latched
// into pending bits; the lowest-index pending line that is enabled by the mask
// is presented to a consumer with a valid/ack handshake.
// Ports:
//   clk               : clock, all state changes on the rising edge
//   rst               : synchronous active-high reset
//   irq        [7:0]  : request lines, index 0 = highest priority
//   en                : global enable for presenting requests
//   mask_we           : write strobe for the mask register
//   mask_wdata [7:0]  : value loaded into the mask on mask_we
//   ack               : consumer accepts the presented request
//   req_valid         : a request is presented
//   req_id     [2:0]  : index of the presented request
//   pending    [7:0]  : latched pending bits, independent of the mask
//   mask       [7:0]  : current mask register (1 = line enabled)
// Timing: a rise sampled at edge N is recorded at edge N, becomes pending at
// edge N+1 and is presented after edge N+2.
// -----------------------------------------------------------------------------
module irq_encoder8
   import irq_encoder8_pkg::*;
#(
   parameter logic [N_IRQ-1:0] RESET_MASK = 8'hFF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq,
   input  logic             en,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   input  logic             ack,
   output logic             req_valid,
   output logic [ID_W-1:0]  req_id,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);

   // ---------------------------------------------------------------- state
   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_IRQ-1:0]   r_irq_q;
   logic [N_IRQ-1:0]   r_rise;
   logic [N_IRQ-1:0]   r_pending;
   logic [N_IRQ-1:0]   r_mask;
   logic [ID_W-1:0]    r_req_id;

   // ---------------------------------------------------------------- wires
   logic [N_IRQ-1:0]   w_eligible;
   logic [ID_W-1:0]    w_enc_id;
   logic               w_enc_any;
   logic               w_grant;
   logic               w_ack_clr;
   logic [N_IRQ-1:0]   w_clr_vec;
   logic [N_IRQ-1:0]   w_pending_nxt;

   // Only masked-in pending lines compete; masked lines keep their pending
   // bit and join the competition as soon as they are unmasked.
   assign w_eligible = r_pending & r_mask;

   prio_enc8 u_prio_enc8 (
      .i_req (w_eligible),
      .o_id  (w_enc_id),
      .o_any (w_enc_any)
   );

   // Clearing the acknowledged line and setting from a recorded rise happen
   // on the same edge; OR-ing the rise in last makes the set win.
   assign w_clr_vec     = w_ack_clr ? id_to_onehot(r_req_id) : '0;
   assign w_pending_nxt = (r_pending & ~w_clr_vec) | r_rise;

   // ------------------------------------------------ FSM: state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples
      // the values from before the edge, independent of statement order.
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------ FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_ack_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            // An ack arriving here is deliberately ignored.
            if (en && w_enc_any) begin
               w_state_nxt = PRESENT;
               w_grant     = 1'b1;
            end
         end
         PRESENT: begin
            // The presented id is held (no preemption) until accepted or
            // withdrawn. Acceptance takes precedence over withdrawal when both
            // happen together, since the consumer has already taken it.
            if (ack) begin
               w_state_nxt = IDLE;
               w_ack_clr   = 1'b1;
            end else if (!en) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------ FSM: outputs
   // Every output is driven straight from a register.
   always_comb begin
      req_valid = (r_state == PRESENT);
      req_id    = r_req_id;
      pending   = r_pending;
      mask      = r_mask;
   end

   // ------------------------------------------------ datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq_q   <= '0;
         r_rise    <= '0;
         r_pending <= '0;
         r_mask    <= RESET_MASK;
         r_req_id  <= '0;
      end else begin
         // A level-held line produces exactly one rise; it must drop before
         // another event can be recorded.
         r_irq_q   <= irq;
         r_rise    <= irq & ~r_irq_q;
         r_pending <= w_pending_nxt;
         if (mask_we) begin
            r_mask <= mask_wdata;
         end
         // The id is captured only when a request is granted, so later mask
         // writes or new pending bits cannot disturb a presented request.
         if (w_grant) begin
            r_req_id <= w_enc_id;
         end
      end
   end

endmodule
